// File: rtl/rr_fifo_arb_if.sv
// rtl/rr_fifo_arb_if.sv - producer/consumer handshake bundle for rr_fifo_arb
interface rr_fifo_arb_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int SRC_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                   i_flush;
  logic [N_REQ-1:0]       i_req_valid;
  logic [N_REQ*WIDTH-1:0] i_req_data;
  logic [N_REQ-1:0]       o_req_ready;
  logic                   o_valid;
  logic [WIDTH-1:0]       o_data;
  logic [SRC_W-1:0]       o_src;
  logic                   i_ready;
  logic [CNT_W-1:0]       o_count;
  logic                   o_full;
  logic                   o_empty;

  modport master (
    output i_flush, i_req_valid, i_req_data, i_ready,
    input  o_req_ready, o_valid, o_data, o_src, o_count, o_full, o_empty
  );

  modport slave (
    input  i_flush, i_req_valid, i_req_data, i_ready,
    output o_req_ready, o_valid, o_data, o_src, o_count, o_full, o_empty
  );
endinterface

// File: rtl/rr_fifo_arb.sv
// rtl/rr_fifo_arb.sv - round-robin arbitrated shared FIFO, N_REQ producers to one consumer
module rr_fifo_arb #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input logic           i_clk,
  input logic           i_arstn,
  rr_fifo_arb_if.slave  bus
);
  localparam int MIN_DEPTH = 2;
  localparam int MAX_DEPTH = 64;
  localparam int SRC_W     = $clog2(N_REQ);
  localparam int CNT_W     = $clog2(DEPTH) + 1;
  localparam int AW        = $clog2(DEPTH);

  localparam bit PARAMCHECK_ALLGOOD =
    (N_REQ >= 2) && (N_REQ <= 16) &&
    (WIDTH >= 1) && (WIDTH <= 64) &&
    (DEPTH >= MIN_DEPTH) && (DEPTH <= MAX_DEPTH) &&
    ((DEPTH & (DEPTH - 1)) == 0);

  if (!PARAMCHECK_ALLGOOD) begin : g_param_error
    $error("rr_fifo_arb: illegal parameter combination");
    $info("rr_fifo_arb: N_REQ=%0d WIDTH=%0d DEPTH=%0d", N_REQ, WIDTH, DEPTH);
  end

  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CNT_W-1:0] count;
  logic [SRC_W-1:0] rr;

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [SRC_W-1:0] mem_src  [DEPTH];

  logic             grant_any;
  logic [SRC_W-1:0] grant;
  logic [WIDTH-1:0] grant_data;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push;

  // Round-robin pick: scan rr..N_REQ-1 first, then wrap to 0..rr-1.
  always_comb begin
    grant_any  = 1'b0;
    grant      = '0;
    grant_data = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!grant_any && bus.i_req_valid[j] && (j >= int'(rr))) begin
        grant_any  = 1'b1;
        grant      = SRC_W'(j);
        grant_data = bus.i_req_data[j*WIDTH +: WIDTH];
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!grant_any && bus.i_req_valid[j] && (j < int'(rr))) begin
        grant_any  = 1'b1;
        grant      = SRC_W'(j);
        grant_data = bus.i_req_data[j*WIDTH +: WIDTH];
      end
    end
  end

  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && bus.i_ready;
  assign push  = grant_any && (!full || pop) && !bus.i_flush;

  assign bus.o_req_ready = push ? (N_REQ'(1) << grant) : '0;
  assign bus.o_valid     = !empty;
  assign bus.o_full      = full;
  assign bus.o_empty     = empty;
  assign bus.o_count     = count;
  // Storage is not reset, so the head is gated to keep outputs at zero when empty.
  assign bus.o_data      = empty ? '0 : mem_data[rd_ptr];
  assign bus.o_src       = empty ? '0 : mem_src[rd_ptr];

  // Pointers, occupancy and round-robin pointer; flush clears all but rr.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      rr     <= '0;
    end else begin
      if (push) begin
        rr <= (grant == SRC_W'(N_REQ - 1)) ? '0 : grant + SRC_W'(1);
      end
      if (bus.i_flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end

  // Entry storage written with the winning word and its source index.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_data[wr_ptr] <= grant_data;
      mem_src[wr_ptr]  <= grant;
    end
  end
endmodule

// File: tb/tb_rr_fifo_arb.sv
// tb/tb_rr_fifo_arb.sv - directed self-checking bench for rr_fifo_arb
module tb_rr_fifo_arb;
  logic clk;
  logic arstn;

  rr_fifo_arb_if #(.N_REQ(4), .WIDTH(8), .DEPTH(8)) bus ();

  rr_fifo_arb #(.N_REQ(4), .WIDTH(8), .DEPTH(8)) dut (
    .i_clk   (clk),
    .i_arstn (arstn),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] pdata [4];
  logic [9:0] q [$];
  logic       retire;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.i_req_data = {pdata[3], pdata[2], pdata[1], pdata[0]};
  endtask

  // Sample mid-cycle, check against the queue model, advance one clock, update model.
  task automatic do_cycle(input logic [3:0] exp_ready);
    int   g;
    logic pushed;
    logic popped;
    logic flushed;
    g = 0;
    pushed = 1'b0;
    #4;
    chk("req_ready", 32'(bus.o_req_ready), 32'(exp_ready));
    chk("count", 32'(bus.o_count), q.size());
    chk("empty", 32'(bus.o_empty), 32'(q.size() == 0));
    chk("full", 32'(bus.o_full), 32'(q.size() == 8));
    chk("valid", 32'(bus.o_valid), 32'(q.size() != 0));
    popped  = (q.size() != 0) && bus.i_ready;
    flushed = bus.i_flush;
    if (popped) begin
      chk("head_data", 32'(bus.o_data), 32'(q[0][7:0]));
      chk("head_src", 32'(bus.o_src), 32'(q[0][9:8]));
    end
    for (int i = 0; i < 4; i++) begin
      if (exp_ready[i]) begin
        g = i;
        pushed = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (popped) void'(q.pop_front());
    if (pushed) begin
      q.push_back({2'(g), pdata[g]});
      pdata[g] = pdata[g] + 8'h31;
      if (retire) bus.i_req_valid[g] = 1'b0;
      drive();
    end
    if (flushed) q.delete();
  endtask

  initial begin
    arstn           = 1'b0;
    retire          = 1'b0;
    bus.i_flush     = 1'b0;
    bus.i_ready     = 1'b0;
    bus.i_req_valid = 4'b0000;
    pdata[0] = 8'h10;
    pdata[1] = 8'h21;
    pdata[2] = 8'h42;
    pdata[3] = 8'h83;
    drive();

    // Reset values
    #2;
    chk("rst_count", 32'(bus.o_count), 0);
    chk("rst_empty", 32'(bus.o_empty), 1);
    chk("rst_full", 32'(bus.o_full), 0);
    chk("rst_valid", 32'(bus.o_valid), 0);
    chk("rst_data", 32'(bus.o_data), 0);
    chk("rst_src", 32'(bus.o_src), 0);
    chk("rst_ready", 32'(bus.o_req_ready), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    arstn = 1'b1;

    // All producers valid, consumer stalled: grants 0,1,2,3,0,1,2,3 then full
    bus.i_req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) do_cycle(4'(1 << (k % 4)));
    do_cycle(4'b0000);
    do_cycle(4'b0000);

    // Full with concurrent pop: one in, one out each cycle, count stays 8
    bus.i_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) retire = 1'b1;
      do_cycle(4'(1 << (k % 4)));
    end

    // Drain
    for (int k = 0; k < 8; k++) do_cycle(4'b0000);
    chk("drain_empty", 32'(bus.o_empty), 1);

    // Single producer 2 with 0xA5 into empty FIFO, then rr lands on 3
    bus.i_ready     = 1'b0;
    pdata[2]        = 8'hA5;
    drive();
    bus.i_req_valid = 4'b0100;
    do_cycle(4'b0100);
    chk("p2_valid", 32'(bus.o_valid), 1);
    chk("p2_data", 32'(bus.o_data), 32'h0A5);
    chk("p2_src", 32'(bus.o_src), 2);
    bus.i_req_valid = 4'b1011;
    bus.i_ready     = 1'b1;
    do_cycle(4'b1000);
    do_cycle(4'b0001);
    do_cycle(4'b0010);
    do_cycle(4'b0000);

    // Pointer wrap: 12 pushes interleaved with 12 pops through producer 1
    retire          = 1'b0;
    bus.i_req_valid = 4'b0010;
    for (int k = 0; k < 11; k++) do_cycle(4'b0010);
    retire = 1'b1;
    do_cycle(4'b0010);
    do_cycle(4'b0000);
    chk("wrap_count", 32'(bus.o_count), 0);
    chk("wrap_empty", 32'(bus.o_empty), 1);

    // Flush at count 5; rr (=1) survives the flush
    retire          = 1'b0;
    bus.i_ready     = 1'b0;
    bus.i_req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) do_cycle(4'b0001);
    bus.i_req_valid = 4'b1111;
    bus.i_flush     = 1'b1;
    bus.i_ready     = 1'b1;
    do_cycle(4'b0000);
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b0;
    chk("flush_count", 32'(bus.o_count), 0);
    chk("flush_valid", 32'(bus.o_valid), 0);
    do_cycle(4'b0010);

    // Asynchronous reset mid-burst at count 3
    do_cycle(4'b0100);
    do_cycle(4'b1000);
    chk("pre_rst_count", 32'(bus.o_count), 3);
    #2;
    arstn = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_count", 32'(bus.o_count), 0);
    chk("mid_rst_empty", 32'(bus.o_empty), 1);
    chk("mid_rst_full", 32'(bus.o_full), 0);
    chk("mid_rst_valid", 32'(bus.o_valid), 0);
    chk("mid_rst_data", 32'(bus.o_data), 0);
    chk("mid_rst_src", 32'(bus.o_src), 0);
    chk("mid_rst_ready", 32'(bus.o_req_ready), 32'h1);
    @(posedge clk);
    #1;
    arstn = 1'b1;
    do_cycle(4'b0001);
    do_cycle(4'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
